// File: rtl/conv_rr_scheduler.sv
// Round-robin scheduler sharing one streaming convolution engine among R requesters.
// One job = N words routed into the engine, then L = N-M+1 result words routed back.
module conv_rr_scheduler #(
    parameter int R = 4,
    parameter int N = 32,
    parameter int M = 10,
    parameter int T = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R*T-1:0] req_x_data,
    input  logic [R-1:0]   req_x_valid,
    output logic [R-1:0]   req_x_ready,
    output logic [R*T-1:0] req_y_data,
    output logic [R-1:0]   req_y_valid,
    input  logic [R-1:0]   req_y_ready,
    output logic [T-1:0]   eng_x_data,
    output logic           eng_x_valid,
    input  logic           eng_x_ready,
    input  logic [T-1:0]   eng_y_data,
    input  logic           eng_y_valid,
    output logic           eng_y_ready,
    output logic [R-1:0]   grant,
    output logic           busy,
    output logic           job_done,
    output logic [1:0]     dbg_state
);
    localparam int L  = N - M + 1;
    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam int XW = $clog2(N + 1);
    localparam int YW = $clog2(L + 1);

    // Handshakes: a word moves on a clock edge where valid && ready are both high;
    // the owner's valid/ready are forwarded combinationally to/from the engine.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [R-1:0]    grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [XW-1:0]   x_cnt_q, x_cnt_d;
    logic [YW-1:0]   y_cnt_q, y_cnt_d;
    logic [R-1:0]    pick_oh;
    logic            found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        pick_oh     = '0;
        found       = 1'b0;
        req_x_ready = '0;
        req_y_valid = '0;
        req_y_data  = {R{eng_y_data}};
        eng_x_data  = '0;
        eng_x_valid = 1'b0;
        eng_y_ready = 1'b0;
        job_done    = 1'b0;

        // First pass scans ptr..R-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < R; i++) begin
            if (!found && req_x_valid[i] && (i >= int'(ptr_q))) begin
                found      = 1'b1;
                pick_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < R; i++) begin
            if (!found && req_x_valid[i]) begin
                found      = 1'b1;
                pick_oh[i] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick_oh;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < R; i++) begin
                    if (grant_q[i]) begin
                        eng_x_data     = req_x_data[i*T +: T];
                        eng_x_valid    = req_x_valid[i];
                        req_x_ready[i] = eng_x_ready;
                    end
                end
                if (eng_x_valid && eng_x_ready) begin
                    if (x_cnt_q == XW'(N - 1)) begin
                        x_cnt_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        x_cnt_d = x_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                for (int i = 0; i < R; i++) begin
                    if (grant_q[i]) begin
                        req_y_valid[i] = eng_y_valid;
                        eng_y_ready    = req_y_ready[i];
                    end
                end
                if (eng_y_valid && eng_y_ready) begin
                    if (y_cnt_q == YW'(L - 1)) begin
                        job_done = 1'b1;
                        y_cnt_d  = '0;
                        grant_d  = '0;
                        state_d  = S_IDLE;
                        // Priority moves to the requester just after the one served.
                        for (int i = 0; i < R; i++) begin
                            if (grant_q[i]) begin
                                ptr_d = (i == R - 1) ? '0 : IW'(i + 1);
                            end
                        end
                    end else begin
                        y_cnt_d = y_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign grant     = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_rr_scheduler.sv
// Bench for conv_rr_scheduler: bench-side requesters and engine stub, job-order
// reference model (queue-based rotation), and a negedge scoreboard monitor.
module tb_conv_rr_scheduler;
    localparam int R = 4;
    localparam int N = 32;
    localparam int M = 10;
    localparam int T = 16;
    localparam int L = N - M + 1;

    logic           clk;
    logic           reset;
    logic [R*T-1:0] req_x_data;
    logic [R-1:0]   req_x_valid;
    logic [R-1:0]   req_x_ready;
    logic [R*T-1:0] req_y_data;
    logic [R-1:0]   req_y_valid;
    logic [R-1:0]   req_y_ready;
    logic [T-1:0]   eng_x_data;
    logic           eng_x_valid;
    logic           eng_x_ready;
    logic [T-1:0]   eng_y_data;
    logic           eng_y_valid;
    logic           eng_y_ready;
    logic [R-1:0]   grant;
    logic           busy;
    logic           job_done;
    logic [1:0]     dbg_state;

    conv_rr_scheduler #(.R(R), .N(N), .M(M), .T(T)) dut (
        .clk(clk), .reset(reset),
        .req_x_data(req_x_data), .req_x_valid(req_x_valid), .req_x_ready(req_x_ready),
        .req_y_data(req_y_data), .req_y_valid(req_y_valid), .req_y_ready(req_y_ready),
        .eng_x_data(eng_x_data), .eng_x_valid(eng_x_valid), .eng_x_ready(eng_x_ready),
        .eng_y_data(eng_y_data), .eng_y_valid(eng_y_valid), .eng_y_ready(eng_y_ready),
        .grant(grant), .busy(busy), .job_done(job_done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- shared state ----------------
    int checks = 0;
    int errors = 0;
    logic [T-1:0] rq[R][$];          // words each requester still has to send
    logic [R-1:0] exp_grant_q[$];    // expected grant order
    logic [T+1:0] exp_x_q[$];        // {owner, word} expected into engine
    logic [T+2:0] exp_y_q[$];        // {last, owner, word} expected back out
    logic [T-1:0] ex_buf[$];         // engine stub: x words of current job
    logic [T-1:0] ey_q[$];           // engine stub: y words to emit
    bit garbage;
    bit rand_mode;
    int hold;
    int ycnt;
    int mptr;
    int done_cnt;
    int exp_jobs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [R-1:0] onehot_of(input int g);
        logic [R-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic bit rq_empty();
        for (int i = 0; i < R; i++)
            if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: all listed jobs are requested together; serve by rotation from mptr.
    task automatic plan(input int n0, input int n1, input int n2, input int n3);
        int pend[R];
        int total;
        int g;
        logic [T-1:0] w[N];
        pend[0] = n0; pend[1] = n1; pend[2] = n2; pend[3] = n3;
        total = n0 + n1 + n2 + n3;
        while (total > 0) begin
            g = -1;
            for (int k = 0; k < R; k++) begin
                int c;
                c = (mptr + k) % R;
                if (g < 0 && pend[c] > 0) g = c;
            end
            exp_grant_q.push_back(onehot_of(g));
            for (int k = 0; k < N; k++) begin
                w[k] = T'($urandom);
                rq[g].push_back(w[k]);
                exp_x_q.push_back({2'(g), w[k]});
            end
            for (int k = 0; k < L; k++)
                exp_y_q.push_back({(k == L - 1), 2'(g), w[k] ^ 16'h5A5A});
            pend[g]--;
            total--;
            mptr = (g + 1) % R;
            exp_jobs++;
        end
    endtask

    // ---------------- driver: requesters + engine stub ----------------
    task automatic update_models();
        for (int i = 0; i < R; i++)
            if (req_x_valid[i] && req_x_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (eng_x_valid && eng_x_ready) begin
            ex_buf.push_back(eng_x_data);
            if (ex_buf.size() == N) begin
                for (int k = 0; k < L; k++) ey_q.push_back(ex_buf[k] ^ 16'h5A5A);
                ex_buf.delete();
            end
        end
        if (eng_y_valid && eng_y_ready && ey_q.size() > 0) begin
            void'(ey_q.pop_front());
            ycnt++;
            if (ycnt == 5 && rand_mode) hold = 7;
            if (ycnt == L) ycnt = 0;
        end
    endtask

    task automatic drive_inputs();
        if (garbage) begin
            req_x_data  = {$urandom, $urandom};
            req_x_valid = R'($urandom);
            req_y_ready = R'($urandom);
            eng_x_ready = 1'($urandom);
            eng_y_data  = T'($urandom);
            eng_y_valid = 1'($urandom);
            return;
        end
        for (int i = 0; i < R; i++) begin
            bit has;
            has = (rq[i].size() > 0);
            req_x_data[i*T +: T] = has ? rq[i][0] : T'($urandom);
            req_x_valid[i] = has && (!(rand_mode && grant[i]) || ($urandom_range(0, 3) != 0));
            req_y_ready[i] = (hold > 0) ? 1'b0 : (!rand_mode || ($urandom_range(0, 2) != 0));
        end
        if (hold > 0) hold--;
        eng_x_ready = (ey_q.size() == 0) && (!rand_mode || ($urandom_range(0, 1) != 0));
        if (ey_q.size() > 0) begin
            eng_y_valid = !rand_mode || ($urandom_range(0, 3) != 0);
            eng_y_data  = ey_q[0];
        end else begin
            eng_y_valid = rand_mode && ($urandom_range(0, 1) != 0);
            eng_y_data  = T'($urandom);
        end
    endtask

    initial begin
        req_x_data = '0; req_x_valid = '0; req_y_ready = '0;
        eng_x_ready = 1'b0; eng_y_data = '0; eng_y_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) update_models();
            @(posedge clk);
            #1;
            drive_inputs();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [R-1:0] prev_grant;
    bit prev_any;
    bit prev_done;

    always @(negedge clk) begin
        if (!reset) begin
            prev_grant = '0;
            prev_any   = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (grant == '0) begin
                chk("idle_outputs", {busy, job_done, eng_x_valid, eng_y_ready,
                                     req_x_ready, req_y_valid, eng_x_data}, 64'd0);
            end else begin
                chk("grant_onehot", $onehot(grant), 1);
                chk("busy_owned", busy, 1);
                chk("non_owner_quiet", {req_x_ready & ~grant, req_y_valid & ~grant}, 0);
            end
            if (prev_grant == '0 && prev_any) chk("arb_latency", (grant != '0), 1);
            if (prev_done) chk("idle_gap", grant, 0);
            if (prev_grant == '0 && grant != '0) begin
                if (exp_grant_q.size() == 0) chk("grant_unexpected", grant, 0);
                else chk("grant_order", grant, exp_grant_q.pop_front());
                if (!rand_mode) chk("first_x_offered", eng_x_valid, 1);
            end
            if (eng_x_valid && eng_x_ready) begin
                if (exp_x_q.size() == 0) chk("x_unexpected", 1, 0);
                else begin
                    logic [T+1:0] e;
                    e = exp_x_q.pop_front();
                    chk("x_data", eng_x_data, e[T-1:0]);
                    chk("x_owner", grant, onehot_of(int'(e[T+1:T])));
                end
            end
            if (eng_y_valid && eng_y_ready) begin
                if (exp_y_q.size() == 0) chk("y_unexpected", 1, 0);
                else begin
                    logic [T+2:0] e;
                    int o;
                    e = exp_y_q.pop_front();
                    o = int'(e[T+1:T]);
                    chk("y_route", req_y_valid, onehot_of(o));
                    chk("y_data", req_y_data[o*T +: T], e[T-1:0]);
                    chk("job_done_last", job_done, e[T+2]);
                end
            end else begin
                chk("job_done_quiet", job_done, 0);
            end
            if (job_done) done_cnt++;
            prev_grant = grant;
            prev_any   = |req_x_valid;
            prev_done  = job_done;
        end
    end

    // ---------------- sequencing ----------------
    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (rq_empty() && exp_x_q.size() == 0 && exp_y_q.size() == 0 &&
                exp_grant_q.size() == 0 && grant == '0) ok = 1'b1;
        end
        chk({name, "_drained"}, ok, 1);
        chk({name, "_jobs_done"}, done_cnt, exp_jobs);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {req_x_ready, req_y_valid, eng_x_valid, eng_y_ready, eng_x_data,
                   grant, busy, job_done}, 64'd0);
        chk({name, "_ydata"}, req_y_data, {R{eng_y_data}});
    endtask

    initial begin
        reset = 1'b0;
        garbage = 1'b1;
        rand_mode = 1'b0;
        hold = 0; ycnt = 0; mptr = 0; done_cnt = 0; exp_jobs = 0;

        repeat (4) begin
            @(posedge clk);
            #2;
            check_reset_outputs("reset_outputs");
        end
        garbage = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", {grant, busy}, 0);
        end

        plan(0, 0, 1, 0);
        wait_drain("single");
        plan(0, 0, 0, 1);
        wait_drain("req3");
        plan(2, 1, 1, 1);
        wait_drain("fairness");
        plan(0, 0, 0, 1);
        wait_drain("skip_pre");
        plan(0, 1, 0, 1);
        wait_drain("skip");

        rand_mode = 1'b1;
        for (int p = 0; p < 3; p++) begin
            int n[R];
            for (int i = 0; i < R; i++) n[i] = $urandom_range(0, 1);
            if (n[0] + n[1] + n[2] + n[3] == 0) n[$urandom_range(0, R - 1)] = 1;
            plan(n[0], n[1], n[2], n[3]);
            wait_drain("backpressure");
        end
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);

        plan(0, 1, 0, 0);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                @(posedge clk);
                #3;
                if (ex_buf.size() >= 10) hit = 1'b1;
            end
            chk("reach_10_words", ex_buf.size(), 10);
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        for (int i = 0; i < R; i++) rq[i].delete();
        exp_grant_q.delete(); exp_x_q.delete(); exp_y_q.delete();
        ex_buf.delete(); ey_q.delete();
        hold = 0; ycnt = 0; mptr = 0;
        exp_jobs = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        plan(1, 0, 1, 0);
        wait_drain("restart");

        chk("queues_empty", exp_x_q.size() + exp_y_q.size() + exp_grant_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
